// File: rtl/crop_window_ctrl.sv
// -----------------------------------------------------------------------------
// crop_window_ctrl
//
// Frame-level controller for the crop filter. It follows the raster position
// of every accepted pixel beat, owns the active crop window, and takes new
// window configurations through a valid/ready port. Configurations are range
// checked. A configuration that arrives while a frame is running is held in a
// one-deep pending slot. It is applied only on the frame's last beat, so no
// frame is ever cropped with a mix of two windows.
//
// Optional feature macro: CROP_CTRL_FRAME_CNT_EN
//   defined   -> 16-bit completed-frame counter on frame_cnt (wraps to 0)
//   undefined -> no counter logic, frame_cnt tied to 0
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   enable     run frames while high
//   in_valid   pixel presented upstream
//   out_ready  downstream ready; a beat is in_valid && out_ready
//   cfg_valid  configuration request
//   cfg_ready  configuration can be accepted (registered)
//   cfg_x1     requested left column      cfg_w  requested width
//   cfg_y1     requested top row          cfg_h  requested height
//   cfg_err    one-cycle pulse, configuration rejected
//   win_x1/w   active window columns      win_y1/h  active window rows
//   pix_x      column of current beat     pix_y     row of current beat
//   pix_keep   current beat is inside the active window (combinational)
//   sof / eof  one-cycle frame start / end markers
//   busy       a frame is in progress
//   frame_cnt  number of completed frames
// -----------------------------------------------------------------------------
module crop_window_ctrl #(
  parameter int IN_ROWS = 40,
  parameter int IN_COLS = 40,
  parameter int DEF_X1  = 10,
  parameter int DEF_Y1  = 10,
  parameter int DEF_W   = 20,
  parameter int DEF_H   = 20,
  localparam int CW     = $clog2(IN_COLS + 1),
  localparam int RW     = $clog2(IN_ROWS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          in_valid,
  input  logic          out_ready,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_x1,
  input  logic [CW-1:0] cfg_w,
  input  logic [RW-1:0] cfg_y1,
  input  logic [RW-1:0] cfg_h,
  output logic          cfg_err,
  output logic [CW-1:0] win_x1,
  output logic [CW-1:0] win_w,
  output logic [RW-1:0] win_y1,
  output logic [RW-1:0] win_h,
  output logic [CW-1:0] pix_x,
  output logic [RW-1:0] pix_y,
  output logic          pix_keep,
  output logic          sof,
  output logic          eof,
  output logic          busy,
  output logic [15:0]   frame_cnt
);

  localparam int CW1 = CW + 1;
  localparam int RW1 = RW + 1;

  localparam logic [CW-1:0] X_LAST   = CW'(IN_COLS - 1);
  localparam logic [RW-1:0] Y_LAST   = RW'(IN_ROWS - 1);
  localparam logic [CW:0]   COLS_LIM = CW1'(IN_COLS);
  localparam logic [RW:0]   ROWS_LIM = RW1'(IN_ROWS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Window captured while a frame is running, waiting for the frame end.
  logic          pend_valid;
  logic [CW-1:0] pend_x1;
  logic [CW-1:0] pend_w;
  logic [RW-1:0] pend_y1;
  logic [RW-1:0] pend_h;

  logic          beat;
  logic          take_beat;
  logic          first_beat;
  logic          last_beat;
  logic          at_x_last;
  logic          at_y_last;

  logic [CW:0]   cfg_x_end;
  logic [RW:0]   cfg_y_end;
  logic          cfg_fire;
  logic          cfg_bad;
  logic          cfg_ok;

  logic [CW:0]   win_x_end;
  logic [RW:0]   win_y_end;
  logic          in_win_x;
  logic          in_win_y;

  // ---------------------------------------------------------------------------
  // Beat qualification
  // ---------------------------------------------------------------------------
  // A beat counts only while a frame is running, or when it is the beat that
  // starts a frame from ARM. IDLE ignores traffic completely, and so does ARM
  // once enable has dropped.
  assign beat       = in_valid && out_ready;
  assign take_beat  = beat && ((state == RUN) || ((state == ARM) && enable));
  assign first_beat = take_beat && (state == ARM);
  assign at_x_last  = (pix_x == X_LAST);
  assign at_y_last  = (pix_y == Y_LAST);
  assign last_beat  = take_beat && (state == RUN) && at_x_last && at_y_last;

  // ---------------------------------------------------------------------------
  // Keep decision
  // ---------------------------------------------------------------------------
  // The window end is formed one bit wider, so a window that reaches the last
  // column or row cannot wrap around and exclude itself.
  assign win_x_end = {1'b0, win_x1} + {1'b0, win_w};
  assign win_y_end = {1'b0, win_y1} + {1'b0, win_h};
  assign in_win_x  = ({1'b0, pix_x} >= {1'b0, win_x1}) && ({1'b0, pix_x} < win_x_end);
  assign in_win_y  = ({1'b0, pix_y} >= {1'b0, win_y1}) && ({1'b0, pix_y} < win_y_end);
  assign pix_keep  = take_beat && in_win_x && in_win_y;

  // ---------------------------------------------------------------------------
  // Configuration check
  // ---------------------------------------------------------------------------
  assign cfg_x_end = {1'b0, cfg_x1} + {1'b0, cfg_w};
  assign cfg_y_end = {1'b0, cfg_y1} + {1'b0, cfg_h};
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign cfg_bad   = (cfg_w == '0) || (cfg_h == '0) ||
                     (cfg_x_end > COLS_LIM) || (cfg_y_end > ROWS_LIM);
  assign cfg_ok    = cfg_fire && !cfg_bad;

  // The pending slot is the only thing that back-pressures the config port.
  // pend_valid is a flop, so cfg_ready is a registered output.
  assign cfg_ready = !pend_valid;
  assign busy      = (state == RUN);

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state elements are written with non-blocking assignments, so every
    // flop samples the values from before the edge, whatever the statement order.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: the default comes first, so every path assigns state_next and the
    // block stays purely combinational (no latch).
    state_next = state;
    unique case (state)
      IDLE: begin
        if (enable) state_next = ARM;
      end
      ARM: begin
        if (!enable)        state_next = IDLE;
        else if (take_beat) state_next = RUN;
      end
      RUN: begin
        // A frame that has started always runs to its last beat. enable only
        // decides whether to re-arm afterwards.
        if (last_beat) state_next = enable ? ARM : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Raster position and frame markers
  // ---------------------------------------------------------------------------
  // Outside RUN the position is already (0,0). Reset puts it there, and so
  // does the last beat of every frame. The frame-starting beat in ARM
  // therefore advances from the origin like any other beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_x <= '0;
      pix_y <= '0;
      sof   <= 1'b0;
      eof   <= 1'b0;
    end else begin
      sof <= first_beat;
      eof <= last_beat;
      if (take_beat) begin
        if (at_x_last) begin
          pix_x <= '0;
          pix_y <= at_y_last ? '0 : pix_y + RW'(1);
        end else begin
          pix_x <= pix_x + CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Active window and pending configuration
  // ---------------------------------------------------------------------------
  // The pending window moves to the active window on the last beat. A config
  // accepted in that same cycle can only land in the slot if the slot was
  // empty (cfg_ready), so the two writes to pend_valid never collide. Such a
  // config waits for the following frame's last beat. Later statements win
  // for the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_x1     <= CW'(DEF_X1);
      win_w      <= CW'(DEF_W);
      win_y1     <= RW'(DEF_Y1);
      win_h      <= RW'(DEF_H);
      pend_valid <= 1'b0;
      pend_x1    <= '0;
      pend_w     <= '0;
      pend_y1    <= '0;
      pend_h     <= '0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= cfg_fire && cfg_bad;

      if (last_beat && pend_valid) begin
        win_x1     <= pend_x1;
        win_w      <= pend_w;
        win_y1     <= pend_y1;
        win_h      <= pend_h;
        pend_valid <= 1'b0;
      end

      if (cfg_ok) begin
        if (state == RUN) begin
          pend_x1    <= cfg_x1;
          pend_w     <= cfg_w;
          pend_y1    <= cfg_y1;
          pend_h     <= cfg_h;
          pend_valid <= 1'b1;
        end else begin
          // No frame is in flight, so the window can change right away. A
          // beat in this same cycle still sees the old window.
          win_x1 <= cfg_x1;
          win_w  <= cfg_w;
          win_y1 <= cfg_y1;
          win_h  <= cfg_h;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completed-frame counter
  // ---------------------------------------------------------------------------
`ifdef CROP_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Updated on the last-beat edge, so the new count shows up together with eof.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (last_beat) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_crop_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_crop_window_ctrl
//
// Directed bench for crop_window_ctrl with the default 40x40 geometry and the
// default 10,10,20,20 window. Beats are driven just after the rising edge.
// Outputs are sampled on the falling edge. For every accepted beat, the
// expected raster position comes from the bench's own beat count. Keep
// counts, sof/eof positions and frame counts are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_crop_window_ctrl;

  localparam int COLS  = 40;
  localparam int ROWS  = 40;
  localparam int FRAME = COLS * ROWS;

`ifdef CROP_CTRL_FRAME_CNT_EN
  localparam int FC_EN = 1;
`else
  localparam int FC_EN = 0;
`endif

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       enable    = 1'b0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [5:0] cfg_x1    = '0;
  logic [5:0] cfg_w     = '0;
  logic [5:0] cfg_y1    = '0;
  logic [5:0] cfg_h     = '0;

  logic        cfg_ready;
  logic        cfg_err;
  logic [5:0]  win_x1;
  logic [5:0]  win_w;
  logic [5:0]  win_y1;
  logic [5:0]  win_h;
  logic [5:0]  pix_x;
  logic [5:0]  pix_y;
  logic        pix_keep;
  logic        sof;
  logic        eof;
  logic        busy;
  logic [15:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-run observations gathered by run_beats.
  int nb;
  int sof_cnt;
  int eof_cnt;
  int pos_err;
  int keep_nobeat;
  int err_cnt;
  int keep_cnt [2];
  int sof_at   [2];
  int eof_at   [2];
  int ready_mid;
  int ready_last0;
  int ready_eof0;

  crop_window_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_x1    (cfg_x1),
    .cfg_w     (cfg_w),
    .cfg_y1    (cfg_y1),
    .cfg_h     (cfg_h),
    .cfg_err   (cfg_err),
    .win_x1    (win_x1),
    .win_w     (win_w),
    .win_y1    (win_y1),
    .win_h     (win_h),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_keep  (pix_keep),
    .sof       (sof),
    .eof       (eof),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int fc(input int n);
    return (FC_EN != 0) ? (n % 65536) : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input int x1, input int w, input int y1, input int h);
    cfg_x1    = 6'(x1);
    cfg_w     = 6'(w);
    cfg_y1    = 6'(y1);
    cfg_h     = 6'(h);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic record(input bit b);
    if (sof) begin
      if (sof_cnt < 2) sof_at[sof_cnt] = nb;
      sof_cnt++;
    end
    if (eof) begin
      if (eof_cnt < 2) eof_at[eof_cnt] = nb;
      if (eof_cnt == 0) ready_eof0 = int'(cfg_ready);
      eof_cnt++;
    end
    if (cfg_err) err_cnt++;
    if (nb == 1000) ready_mid = int'(cfg_ready);
    if (b && nb == FRAME - 1) ready_last0 = int'(cfg_ready);
    if (b) begin
      if (pix_keep && (nb / FRAME) < 2) keep_cnt[nb / FRAME]++;
      if (int'(pix_x) != nb % COLS || int'(pix_y) != (nb % FRAME) / COLS) pos_err++;
    end else if (pix_keep) begin
      keep_nobeat++;
    end
  endtask

  // Drives nbeats accepted beats, optionally with random gaps on both
  // handshake sides. It optionally presents one config while nb == cfg_at,
  // then adds a few idle cycles so a trailing eof is still observed.
  // Must be entered just after a rising edge.
  task automatic run_beats(input int nbeats, input bit gaps, input int cfg_at,
                           input int cx1, input int cw, input int cy1, input int ch);
    int cycles;
    bit cfg_sent;
    bit b;
    cycles = 0;
    cfg_sent = 1'b0;
    nb = 0; sof_cnt = 0; eof_cnt = 0; pos_err = 0; keep_nobeat = 0; err_cnt = 0;
    keep_cnt = '{0, 0};
    sof_at = '{-1, -1};
    eof_at = '{-1, -1};
    ready_mid = -1; ready_last0 = -1; ready_eof0 = -1;
    while (nb < nbeats && cycles < nbeats * 8 + 100) begin
      if (gaps) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        in_valid  = 1'b1;
        out_ready = 1'b1;
      end
      if (cfg_at >= 0 && nb == cfg_at && !cfg_sent) begin
        cfg_x1 = 6'(cx1); cfg_w = 6'(cw); cfg_y1 = 6'(cy1); cfg_h = 6'(ch);
        cfg_valid = 1'b1;
        cfg_sent  = 1'b1;
      end
      @(negedge clk);
      b = in_valid && out_ready;
      record(b);
      if (b) nb++;
      step();
      cfg_valid = 1'b0;
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      record(1'b0);
      step();
    end
    check("beats_done", nb, nbeats);
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_pix", int'(pix_x) + int'(pix_y), 0);
    check("rst_win", int'({win_x1, win_y1, win_w, win_h}),
          int'({6'd10, 6'd10, 6'd20, 6'd20}));
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_flags", int'({cfg_err, sof, eof}), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);

    // ---------------- one gap-free frame, default window ----------------
    step();
    enable = 1'b1;
    step();
    run_beats(FRAME, 1'b0, -1, 0, 0, 0, 0);
    check("f1_keep", keep_cnt[0], 400);
    check("f1_sof_cnt", sof_cnt, 1);
    check("f1_sof_at", sof_at[0], 1);
    check("f1_eof_cnt", eof_cnt, 1);
    check("f1_eof_at", eof_at[0], FRAME);
    check("f1_pos", pos_err, 0);
    check("f1_keep_nobeat", keep_nobeat, 0);
    @(negedge clk);
    check("f1_frame_cnt", int'(frame_cnt), fc(1));
    check("f1_busy_after", int'(busy), 0);

    // ---------------- full-frame window written in IDLE ----------------
    step();
    enable = 1'b0;
    step();
    send_cfg(0, 40, 0, 40);
    @(negedge clk);
    check("idle_cfg_err", int'(cfg_err), 0);
    check("idle_win", int'({win_x1, win_y1, win_w, win_h}),
          int'({6'd0, 6'd0, 6'd40, 6'd40}));
    step();
    enable = 1'b1;
    step();
    run_beats(FRAME, 1'b0, -1, 0, 0, 0, 0);
    check("full_keep", keep_cnt[0], FRAME);
    check("full_pos", pos_err, 0);
    @(negedge clk);
    check("full_frame_cnt", int'(frame_cnt), fc(2));

    // ---------------- rejected and boundary configs (state ARM) ----------------
    step();
    send_cfg(30, 20, 0, 10);              // 30+20 > 40
    @(negedge clk);
    check("rej1_err", int'(cfg_err), 1);
    check("rej1_win", int'({win_x1, win_w}), int'({6'd0, 6'd40}));
    step();
    @(negedge clk);
    check("rej1_pulse_end", int'(cfg_err), 0);
    step();
    send_cfg(5, 0, 5, 3);                 // zero width
    @(negedge clk);
    check("rej2_err", int'(cfg_err), 1);
    check("rej2_win", int'({win_x1, win_y1, win_w}), int'({6'd0, 6'd0, 6'd40}));
    step();
    send_cfg(20, 20, 39, 1);              // ends exactly on the frame edge
    @(negedge clk);
    check("edge_err", int'(cfg_err), 0);
    check("edge_win", int'({win_x1, win_y1, win_w, win_h}),
          int'({6'd20, 6'd39, 6'd20, 6'd1}));
    step();
    send_cfg(10, 20, 10, 20);
    @(negedge clk);
    check("def_win", int'({win_x1, win_y1, win_w, win_h}),
          int'({6'd10, 6'd10, 6'd20, 6'd20}));
    step();

    // ---------------- config accepted mid-frame ----------------
    run_beats(2 * FRAME, 1'b0, 500, 0, 4, 0, 4);
    check("mid_keep_f0", keep_cnt[0], 400);
    check("mid_keep_f1", keep_cnt[1], 16);
    check("mid_ready_low", ready_mid, 0);
    check("mid_ready_last", ready_last0, 0);
    check("mid_ready_eof", ready_eof0, 1);
    check("mid_eof_cnt", eof_cnt, 2);
    check("mid_eof_at1", eof_at[1], 2 * FRAME);
    check("mid_sof_at1", sof_at[1], FRAME + 1);
    check("mid_err", err_cnt, 0);
    @(negedge clk);
    check("mid_win", int'({win_x1, win_y1, win_w, win_h}),
          int'({6'd0, 6'd0, 6'd4, 6'd4}));
    check("mid_frame_cnt", int'(frame_cnt), fc(4));
    step();

    // ---------------- random gaps, default window ----------------
    send_cfg(10, 20, 10, 20);
    run_beats(2 * FRAME, 1'b1, -1, 0, 0, 0, 0);
    check("gap_keep_f0", keep_cnt[0], 400);
    check("gap_keep_f1", keep_cnt[1], 400);
    check("gap_sof_cnt", sof_cnt, 2);
    check("gap_eof_cnt", eof_cnt, 2);
    check("gap_eof_at0", eof_at[0], FRAME);
    check("gap_eof_at1", eof_at[1], 2 * FRAME);
    check("gap_pos", pos_err, 0);
    check("gap_keep_nobeat", keep_nobeat, 0);
    @(negedge clk);
    check("gap_frame_cnt", int'(frame_cnt), fc(6));
    step();

    // ---------------- reset mid-frame with a pending config ----------------
    run_beats(800, 1'b0, 500, 0, 4, 0, 4);
    check("pre_rst_eof", eof_cnt, 0);
    @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_ready", int'(cfg_ready), 0);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check("mrst_busy", int'(busy), 0);
    check("mrst_pix", int'(pix_x) + int'(pix_y), 0);
    check("mrst_win", int'({win_x1, win_y1, win_w, win_h}),
          int'({6'd10, 6'd10, 6'd20, 6'd20}));
    check("mrst_ready", int'(cfg_ready), 1);
    check("mrst_flags", int'({cfg_err, sof, eof}), 0);
    check("mrst_frame_cnt", int'(frame_cnt), 0);
    step();
    reset = 1'b0;
    step();
    run_beats(FRAME, 1'b0, -1, 0, 0, 0, 0);
    check("post_keep", keep_cnt[0], 400);
    check("post_sof_at", sof_at[0], 1);
    check("post_eof_cnt", eof_cnt, 1);
    check("post_pos", pos_err, 0);
    @(negedge clk);
    check("post_frame_cnt", int'(frame_cnt), fc(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
